// File: rtl/seven_segment_capture_pkg.sv
// Shared 7-segment definitions: the hex segment table (order abcdefg) and
// the inverse decode used by the capture side.
package seven_segment_pkg;

    typedef struct packed {
        logic       bad;
        logic       blank;
        logic [3:0] nibble;
    } seg_decode_t;

    localparam logic [6:0] HEX_SEGMENTS [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // All segments off reads as blank; anything outside the table is bad.
    function automatic seg_decode_t decode_segments(input logic [6:0] seg);
        seg_decode_t r;
        r.bad    = 1'b1;
        r.blank  = 1'b0;
        r.nibble = 4'h0;
        if (seg == 7'b0000000) begin
            r.bad   = 1'b0;
            r.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg == HEX_SEGMENTS[i]) begin
                    r.bad    = 1'b0;
                    r.nibble = 4'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segment_capture_stability_filter.sv
// Registers the scanned bus once and emits a single accept pulse, with the
// accepted sample, after a one-hot digit has been stable for settle_cycles.
module seven_segment_stability_filter #(
    parameter int w_digit       = 8,
    parameter int settle_cycles = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         abcdefgh,
    input  logic [w_digit-1:0] digit,
    output logic               accept,
    output logic [7:0]         acc_seg,
    output logic [w_digit-1:0] acc_dig
);

    localparam int              CNT_W  = $clog2(settle_cycles + 1);
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(settle_cycles);

    logic [7:0]         s_seg_q, s_seg_d;
    logic [w_digit-1:0] s_dig_q, s_dig_d;
    logic [7:0]         prev_seg_q, prev_seg_d;
    logic [w_digit-1:0] prev_dig_q, prev_dig_d;
    logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic               accept_q, accept_d;
    logic [7:0]         acc_seg_q, acc_seg_d;
    logic [w_digit-1:0] acc_dig_q, acc_dig_d;
    logic               same;

    // Accept only on the cycle the run first reaches SETTLE, never again while it stays.
    always_comb begin
        s_seg_d    = abcdefgh;
        s_dig_d    = digit;
        prev_seg_d = s_seg_q;
        prev_dig_d = s_dig_q;
        same       = ({s_seg_q, s_dig_q} == {prev_seg_q, prev_dig_q});
        if (!same) begin
            stab_cnt_d = CNT_W'(1);
        end else if (stab_cnt_q != SETTLE) begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        accept_d  = (stab_cnt_d == SETTLE) && (!same || (stab_cnt_q != SETTLE))
                    && $onehot(s_dig_q);
        acc_seg_d = accept_d ? s_seg_q : acc_seg_q;
        acc_dig_d = accept_d ? s_dig_q : acc_dig_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_q    <= '0;
            s_dig_q    <= '0;
            prev_seg_q <= '0;
            prev_dig_q <= '0;
            stab_cnt_q <= '0;
            accept_q   <= 1'b0;
            acc_seg_q  <= '0;
            acc_dig_q  <= '0;
        end else begin
            s_seg_q    <= s_seg_d;
            s_dig_q    <= s_dig_d;
            prev_seg_q <= prev_seg_d;
            prev_dig_q <= prev_dig_d;
            stab_cnt_q <= stab_cnt_d;
            accept_q   <= accept_d;
            acc_seg_q  <= acc_seg_d;
            acc_dig_q  <= acc_dig_d;
        end
    end

    assign accept  = accept_q;
    assign acc_seg = acc_seg_q;
    assign acc_dig = acc_dig_q;

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed 7-segment bus: decodes accepted digits into
// working slots and publishes the whole number once every digit has been seen.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int w_digit        = 8,
    parameter int settle_cycles  = 4,
    parameter int timeout_cycles = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           abcdefgh,
    input  logic [w_digit-1:0]   digit,
    output logic [w_digit*4-1:0] number,
    output logic [w_digit-1:0]   dots,
    output logic [w_digit-1:0]   blank,
    output logic                 frame_valid,
    output logic [w_digit-1:0]   bad_pattern,
    output logic                 stalled
);

    localparam int             TO_W    = $clog2(timeout_cycles + 1);
    localparam logic [TO_W-1:0] TIMEOUT = TO_W'(timeout_cycles);

    logic               accept;
    logic [7:0]         acc_seg;
    logic [w_digit-1:0] acc_dig;
    seg_decode_t        dec;
    logic               publish;

    logic [w_digit*4-1:0] work_nib_q, work_nib_d;
    logic [w_digit-1:0]   work_dot_q, work_dot_d;
    logic [w_digit-1:0]   work_blank_q, work_blank_d;
    logic [w_digit-1:0]   work_bad_q, work_bad_d;
    logic [w_digit-1:0]   seen_q, seen_d;
    logic [w_digit*4-1:0] number_q, number_d;
    logic [w_digit-1:0]   dots_q, dots_d;
    logic [w_digit-1:0]   blank_q, blank_d;
    logic [w_digit-1:0]   bad_q, bad_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 stalled_q, stalled_d;

    seven_segment_stability_filter #(
        .w_digit       (w_digit),
        .settle_cycles (settle_cycles)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .abcdefgh (abcdefgh),
        .digit    (digit),
        .accept   (accept),
        .acc_seg  (acc_seg),
        .acc_dig  (acc_dig)
    );

    assign dec     = decode_segments(acc_seg[7:1]);
    assign publish = &seen_q;

    // Publishing reads the pre-write working set; an accept in the same cycle
    // lands in the working set and is the first digit of the next frame.
    always_comb begin
        work_nib_d   = work_nib_q;
        work_dot_d   = work_dot_q;
        work_blank_d = work_blank_q;
        work_bad_d   = work_bad_q;
        seen_d       = publish ? '0 : seen_q;
        if (accept) begin
            for (int i = 0; i < w_digit; i++) begin
                if (acc_dig[i]) begin
                    work_nib_d[i*4 +: 4] = dec.nibble;
                    work_dot_d[i]        = acc_seg[0];
                    work_blank_d[i]      = dec.blank;
                    work_bad_d[i]        = dec.bad;
                    seen_d[i]            = 1'b1;
                end
            end
        end
        number_d      = publish ? work_nib_q   : number_q;
        dots_d        = publish ? work_dot_q   : dots_q;
        blank_d       = publish ? work_blank_q : blank_q;
        bad_d         = publish ? work_bad_q   : bad_q;
        frame_valid_d = publish;
    end

    always_comb begin
        if (publish) begin
            to_cnt_d = '0;
        end else if (to_cnt_q < TIMEOUT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
        stalled_d = !publish && (to_cnt_d >= TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_nib_q    <= '0;
            work_dot_q    <= '0;
            work_blank_q  <= '0;
            work_bad_q    <= '0;
            seen_q        <= '0;
            number_q      <= '0;
            dots_q        <= '0;
            blank_q       <= '0;
            bad_q         <= '0;
            frame_valid_q <= 1'b0;
            to_cnt_q      <= '0;
            stalled_q     <= 1'b0;
        end else begin
            work_nib_q    <= work_nib_d;
            work_dot_q    <= work_dot_d;
            work_blank_q  <= work_blank_d;
            work_bad_q    <= work_bad_d;
            seen_q        <= seen_d;
            number_q      <= number_d;
            dots_q        <= dots_d;
            blank_q       <= blank_d;
            bad_q         <= bad_d;
            frame_valid_q <= frame_valid_d;
            to_cnt_q      <= to_cnt_d;
            stalled_q     <= stalled_d;
        end
    end

    assign number      = number_q;
    assign dots        = dots_q;
    assign blank       = blank_q;
    assign bad_pattern = bad_q;
    assign frame_valid = frame_valid_q;
    assign stalled     = stalled_q;

endmodule
